// File: rtl/operand_fetch.sv
// Operand-fetch/issue stage: reads rs1/rs2, bypasses same-cycle writeback,
// tracks pending destination writes in a scoreboard and stalls on RAW/WAW hazards.
module operand_fetch #(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             in_wr,
  input  logic [TAG_W-1:0] in_tag,
  output logic [4:0]       rf_rd_addr0,
  output logic [4:0]       rf_rd_addr1,
  input  logic [31:0]      rf_rd_data0,
  input  logic [31:0]      rf_rd_data1,
  input  logic             wb_ena,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rs1_val,
  output logic [31:0]      out_rs2_val,
  output logic [4:0]       out_rd,
  output logic             out_wr,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      busy
);

  logic [31:0]      busy_reg;
  logic [31:0]      busy_next;
  logic [31:0]      clr_vec;
  logic [31:0]      set_vec;
  logic             out_valid_reg;
  logic [31:0]      rs1_val_reg;
  logic [31:0]      rs2_val_reg;
  logic [4:0]       rd_reg;
  logic             wr_reg;
  logic [TAG_W-1:0] tag_reg;

  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             hazard;
  logic             accept;
  logic [31:0]      rs1_sel;
  logic [31:0]      rs2_sel;

  assign rf_rd_addr0 = in_rs1;
  assign rf_rd_addr1 = in_rs2;

  // Bit 0 of both vectors is tied low so x0 never enters the scoreboard.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_zero
        assign clr_vec[gi] = 1'b0;
        assign set_vec[gi] = 1'b0;
      end else begin : g_reg
        assign clr_vec[gi] = wb_ena && (wb_addr == 5'(gi));
        assign set_vec[gi] = accept && in_wr && (in_rd == 5'(gi));
      end
    end
  endgenerate

  assign raw1   = (in_rs1 != 5'd0) && busy_reg[in_rs1] && !clr_vec[in_rs1];
  assign raw2   = (in_rs2 != 5'd0) && busy_reg[in_rs2] && !clr_vec[in_rs2];
  assign waw    = in_wr && (in_rd != 5'd0) && busy_reg[in_rd] && !clr_vec[in_rd];
  assign hazard = raw1 | raw2 | waw;

  assign in_ready = rst && !hazard && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  // Set is OR-ed after the clear so a same-cycle re-issue keeps the register pending.
  assign busy_next = (busy_reg & ~clr_vec) | set_vec;

  always_comb begin
    rs1_sel = rf_rd_data0;
    if (in_rs1 == 5'd0)
      rs1_sel = 32'd0;
    else if (wb_ena && (wb_addr == in_rs1))
      rs1_sel = wb_data;
  end

  always_comb begin
    rs2_sel = rf_rd_data1;
    if (in_rs2 == 5'd0)
      rs2_sel = 32'd0;
    else if (wb_ena && (wb_addr == in_rs2))
      rs2_sel = wb_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_reg      <= 32'd0;
      out_valid_reg <= 1'b0;
      rs1_val_reg   <= 32'd0;
      rs2_val_reg   <= 32'd0;
      rd_reg        <= 5'd0;
      wr_reg        <= 1'b0;
      tag_reg       <= '0;
    end else begin
      busy_reg <= busy_next;
      if (accept) begin
        out_valid_reg <= 1'b1;
        rs1_val_reg   <= rs1_sel;
        rs2_val_reg   <= rs2_sel;
        rd_reg        <= in_rd;
        wr_reg        <= in_wr;
        tag_reg       <= in_tag;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_rs1_val = rs1_val_reg;
  assign out_rs2_val = rs2_val_reg;
  assign out_rd      = rd_reg;
  assign out_wr      = wr_reg;
  assign out_tag     = tag_reg;
  assign busy        = busy_reg;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage that sits directly upstream of the execute stage and drives the read ports of the RV32 register file.
- Accepts decoded instructions over a valid/ready handshake and reads rs1/rs2 from the register file.
- Forwards same-cycle writeback data and tracks pending destination writes in a 32-bit scoreboard.
- Stalls on RAW/WAW hazards and presents latched operands to execute over a second valid/ready handshake.

Parameters:
TAG_W, 32, width of opaque per-instruction payload (e.g. raw instruction/PC) passed through unchanged

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-low reset
in_valid  input  1  decoded instruction available
in_ready  output  1  stage accepts instruction this cycle
in_rs1  input  5  source register 1 index
in_rs2  input  5  source register 2 index
in_rd  input  5  destination register index
in_wr  input  1  instruction writes in_rd
in_tag  input  TAG_W  passthrough payload
rf_rd_addr0  output  5  register file read address 0; combinationally equals in_rs1
rf_rd_addr1  output  5  register file read address 1; combinationally equals in_rs2
rf_rd_data0  input  32  register file combinational read data 0
rf_rd_data1  input  32  register file combinational read data 1
wb_ena  input  1  writeback strobe, same signal that drives register file wr_ena
wb_addr  input  5  writeback register index
wb_data  input  32  writeback data
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts operands
out_rs1_val  output  32  latched rs1 operand
out_rs2_val  output  32  latched rs2 operand
out_rd  output  5  latched destination index
out_wr  output  1  latched write flag
out_tag  output  TAG_W  latched payload
busy  output  32  scoreboard; bit i = write to xi pending

Behaviour:
- Reset (rst==0 at edge): out_valid=0, busy=0, out_rs1_val/out_rs2_val/out_rd/out_wr/out_tag=0. in_ready is 0 while rst==0. Any held instruction is discarded.
- Reset mid-operation: wb_ena still writes the register file (external) but does not set scoreboard bits.
- Hazard definitions:
  - clr_i = wb_ena && wb_addr==i && i!=0.
  - raw1 = in_rs1!=0 && busy[in_rs1] && !clr_{in_rs1}; raw2 likewise for in_rs2.
  - waw = in_wr && in_rd!=0 && busy[in_rd] && !clr_{in_rd}.
  - hazard = raw1 | raw2 | waw.
- Handshake:
  - in_ready = rst && !hazard && (!out_valid || out_ready).
  - Accept when in_valid && in_ready; the output register loads next edge with out_valid=1.
  - If out_valid && out_ready && !accept, out_valid clears.
  - Outputs hold stable while out_valid && !out_ready.
  - Throughput is 1 instruction/cycle with no hazards; latency is 1 cycle from accept to out_valid.
- Operand select, per source, priority high to low:
  - index==0 -> 0.
  - wb_ena && wb_addr==index -> wb_data (bypass; the register file writes at the same edge).
  - otherwise rf_rd_data.
- Scoreboard, next state:
  - busy_next = (busy & ~clr) | set, where set = onehot(in_rd) if accept && in_wr && in_rd!=0.
  - Set wins over clear for the same register in the same cycle.
  - busy[0] is constantly 0.
  - wb_ena to a non-busy register is legal and leaves busy unchanged.
- Writes to x0 never set busy, never bypass, and never cause stalls.
- in_valid may drop without acceptance; there is no requirement to hold.

Test Plan:
1. Reset, preload x1=5, x2=7 via wb; in rs1=1 rs2=2 rd=3 wr=1 -> accepted, next cycle out_valid=1, out_rs1_val=5, out_rs2_val=7, busy=0x8.
2. RAW: after test 1, in rs1=3 -> in_ready=0 until wb_ena wb_addr=3 wb_data=0x1234; that cycle in_ready=1, accepted, out_rs1_val=0x1234, busy[3] cleared.
3. x0: in rs1=0 rd=0 wr=1, concurrent wb_ena addr=0 data=0xFFFF -> out_rs1_val=0, busy unchanged, no stall.
4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. Then out_ready=1 with 4 back-to-back hazard-free instructions -> 4 outputs on consecutive cycles in order.
5. WAW: busy[5]=1, in rd=5 wr=1 -> stall. Same-cycle wb addr=5 -> accepted, busy[5] stays 1 (set wins).
6. Reset mid-op: busy=0x28, out_valid=1, rst=0 one cycle -> out_valid=0, busy=0, in_ready=0 during reset, 1 after.
